// File: rtl/reg_bank_arbiter_pkg.sv
// Shared definitions for the two-requester register-bank arbiter: FSM state
// encoding, address-width derivation and the round-robin winner selection.
package reg_bank_arbiter_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_e;

    // Address width for a bank of the given depth; a depth below 2 still
    // gets a 1-bit address so port widths never collapse to zero.
    function automatic int calc_aw(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    // Sole requester wins outright; with both requesting, the pointer decides.
    function automatic logic pick_winner(input logic [1:0] req, input logic prio);
        logic win;
        case (req)
            2'b01:   win = 1'b0;
            2'b10:   win = 1'b1;
            default: win = prio;
        endcase
        return win;
    endfunction

endpackage : reg_bank_arbiter_pkg

// File: rtl/reg_bank.sv
// DEPTH x WIDTH flip-flop storage with one write port and one registered
// read port. Every entry and the read register clear on reset.
module reg_bank
    import reg_bank_arbiter_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int AW    = calc_aw(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Storage array: write on the enabled edge, clear everything on reset.
    // NOTE: the array is reset element by element because readers rely on
    // unwritten entries returning zero; that forces flops, not a RAM macro.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Registered read port: holds its last value between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule : reg_bank

// File: rtl/reg_bank_arbiter.sv
// Round-robin arbiter serialising two requesters onto one shared register
// bank. Each access takes an IDLE sampling cycle and an ACCESS cycle; read
// data returns one cycle after the grant with a one-hot valid pulse.
module reg_bank_arbiter
    import reg_bank_arbiter_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int AW    = calc_aw(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         req,
    input  logic [1:0]         we,
    input  logic [2*AW-1:0]    addr,
    input  logic [2*WIDTH-1:0] wdata,
    output logic [1:0]         gnt,
    output logic [1:0]         rvalid,
    output logic [WIDTH-1:0]   rdata
);

    state_e           state_q,  state_d;
    logic             prio_q,   prio_d;
    logic             win_q,    win_d;
    logic             we_q,     we_d;
    logic [AW-1:0]    addr_q,   addr_d;
    logic [WIDTH-1:0] wdata_q,  wdata_d;
    logic [1:0]       gnt_q,    gnt_d;
    logic [1:0]       rvalid_q, rvalid_d;

    logic bank_we;
    logic bank_re;

    // Next-state logic: choose and latch a winner in IDLE, complete it in ACCESS.
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d  = state_q;
        prio_d   = prio_q;
        win_d    = win_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        gnt_d    = 2'b00;
        rvalid_d = 2'b00;

        case (state_q)
            IDLE: begin
                if (req != 2'b00) begin
                    win_d        = pick_winner(req, prio_q);
                    we_d         = win_d ? we[1] : we[0];
                    addr_d       = win_d ? addr[2*AW-1:AW] : addr[AW-1:0];
                    wdata_d      = win_d ? wdata[2*WIDTH-1:WIDTH] : wdata[WIDTH-1:0];
                    gnt_d[win_d] = 1'b1;
                    state_d      = ACCESS;
                end
            end
            ACCESS: begin
                if (!we_q) begin
                    rvalid_d[win_q] = 1'b1;
                end
                prio_d  = ~win_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, latched request, pointer and output pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            prio_q   <= 1'b0;
            win_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            gnt_q    <= 2'b00;
            rvalid_q <= 2'b00;
        end else begin
            state_q  <= state_d;
            prio_q   <= prio_d;
            win_q    <= win_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            gnt_q    <= gnt_d;
            rvalid_q <= rvalid_d;
        end
    end

    // The bank acts only at the edge that closes the ACCESS cycle.
    assign bank_we = (state_q == ACCESS) &&  we_q;
    assign bank_re = (state_q == ACCESS) && !we_q;

    reg_bank #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_bank (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (bank_we),
        .waddr_i (addr_q),
        .wdata_i (wdata_q),
        .re_i    (bank_re),
        .raddr_i (addr_q),
        .rdata_o (rdata)
    );

    assign gnt    = gnt_q;
    assign rvalid = rvalid_q;

endmodule : reg_bank_arbiter

// File: tb/tb_reg_bank_arbiter.sv
// Self-checking bench for reg_bank_arbiter. A transaction-level model keeps
// the bank contents, the pending request of each requester and the
// round-robin pointer; every slot of two cycles is checked against it.
module tb_reg_bank_arbiter;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic               clk;
    logic               rst_n;
    logic [1:0]         req;
    logic [1:0]         we;
    logic [2*AW-1:0]    addr;
    logic [2*WIDTH-1:0] wdata;
    logic [1:0]         gnt;
    logic [1:0]         rvalid;
    logic [WIDTH-1:0]   rdata;

    int total = 0;
    int bad   = 0;

    // Reference model state.
    logic [WIDTH-1:0] model_mem [DEPTH];
    int               model_prio;
    bit               pend    [2];
    bit               p_we    [2];
    logic [AW-1:0]    p_addr  [2];
    logic [WIDTH-1:0] p_wdata [2];

    reg_bank_arbiter #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .we     (we),
        .addr   (addr),
        .wdata  (wdata),
        .gnt    (gnt),
        .rvalid (rvalid),
        .rdata  (rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
        model_prio = 0;
        for (int i = 0; i < 2; i++) begin
            pend[i]    = 1'b0;
            p_we[i]    = 1'b0;
            p_addr[i]  = '0;
            p_wdata[i] = '0;
        end
    endtask

    // Raise a new request for requester i in the model.
    task automatic post(input int i, input bit w, input logic [AW-1:0] a,
                        input logic [WIDTH-1:0] d);
        pend[i]    = 1'b1;
        p_we[i]    = w;
        p_addr[i]  = a;
        p_wdata[i] = d;
    endtask

    task automatic drive_pending();
        for (int i = 0; i < 2; i++) begin
            req[i]                  = pend[i];
            we[i]                   = p_we[i];
            addr[i*AW +: AW]        = p_addr[i];
            wdata[i*WIDTH +: WIDTH] = p_wdata[i];
        end
    endtask

    // One arbitration slot: drive all pending requests, expect the grant on
    // the first edge and completion (write, or read data + valid) on the next.
    task automatic slot(input string tag);
        int               w;
        logic [1:0]       exp_g;
        logic [1:0]       exp_rv;
        logic [WIDTH-1:0] exp_rd;
        @(negedge clk);
        drive_pending();
        w      = (pend[0] && pend[1]) ? model_prio : (pend[0] ? 0 : 1);
        exp_g  = 2'b01 << w;
        @(posedge clk); #1;
        total++;
        if (gnt !== exp_g) begin
            bad++;
            $display("FAIL %s grant: got=%b exp=%b", tag, gnt, exp_g);
        end
        total++;
        if (rvalid !== 2'b00) begin
            bad++;
            $display("FAIL %s rvalid_during_gnt: got=%b exp=00", tag, rvalid);
        end
        @(posedge clk); #1;
        exp_rd = model_mem[p_addr[w]];
        if (p_we[w]) begin
            model_mem[p_addr[w]] = p_wdata[w];
            exp_rv = 2'b00;
        end else begin
            exp_rv = 2'b01 << w;
        end
        pend[w]    = 1'b0;
        model_prio = 1 - w;
        total++;
        if (gnt !== 2'b00) begin
            bad++;
            $display("FAIL %s gnt_drop: got=%b exp=00", tag, gnt);
        end
        total++;
        if (rvalid !== exp_rv) begin
            bad++;
            $display("FAIL %s rvalid: got=%b exp=%b", tag, rvalid, exp_rv);
        end
        if (exp_rv != 2'b00) begin
            total++;
            if (rdata !== exp_rd) begin
                bad++;
                $display("FAIL %s rdata: got=%h exp=%h", tag, rdata, exp_rd);
            end
        end
    endtask

    task automatic go_idle();
        @(negedge clk);
        drive_pending();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = 2'b00;
        we    = 2'b00;
        addr  = '0;
        wdata = '0;
        model_reset();
        repeat (2) @(negedge clk);
        total++;
        if ({gnt, rvalid, rdata} !== '0) begin
            bad++;
            $display("FAIL reset_in: got gnt=%b rvalid=%b rdata=%h exp all 0", gnt, rvalid, rdata);
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({gnt, rvalid, rdata} !== '0) begin
            bad++;
            $display("FAIL reset_idle: got gnt=%b rvalid=%b rdata=%h exp all 0", gnt, rvalid, rdata);
        end
    endtask

    task automatic test_write_read();
        post(0, 1'b1, 2'd2, 8'hA5);
        slot("wr0_write");
        post(0, 1'b0, 2'd2, 8'h00);
        slot("wr0_read");
        go_idle();
    endtask

    task automatic test_unwritten();
        post(1, 1'b0, 2'd3, 8'h00);
        slot("unwritten_read");
        go_idle();
    endtask

    task automatic test_contention();
        post(1, 1'b1, 2'd1, 8'h3C);
        post(0, 1'b0, 2'd1, 8'h00);
        slot("cont_first");
        slot("cont_second");
        post(0, 1'b0, 2'd1, 8'h00);
        slot("cont_reread");
        go_idle();
    endtask

    task automatic test_both_continuous();
        post(0, 1'b0, 2'd0, 8'h00);
        post(1, 1'b0, 2'd1, 8'h00);
        for (int k = 0; k < 6; k++) begin
            int last_w;
            last_w = pend[0] ? (pend[1] ? model_prio : 0) : 1;
            slot("both_alt");
            post(last_w, 1'b0, AW'(k), 8'h00);
        end
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        go_idle();
    endtask

    task automatic test_reset_mid_access();
        post(0, 1'b1, 2'd0, 8'h55);
        slot("rst_pre_write");
        post(0, 1'b0, 2'd0, 8'h00);
        slot("rst_pre_read");
        post(0, 1'b1, 2'd3, 8'hFF);
        @(negedge clk);
        drive_pending();
        @(posedge clk); #1;
        total++;
        if (gnt !== 2'b01) begin
            bad++;
            $display("FAIL rst_mid_grant: got=%b exp=01", gnt);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({gnt, rvalid, rdata} !== '0) begin
            bad++;
            $display("FAIL rst_mid_clear: got gnt=%b rvalid=%b rdata=%h exp all 0", gnt, rvalid, rdata);
        end
        model_reset();
        @(negedge clk);
        drive_pending();
        rst_n = 1'b1;
        post(0, 1'b0, 2'd3, 8'h00);
        slot("rst_read_addr3");
        post(1, 1'b0, 2'd0, 8'h00);
        slot("rst_read_addr0");
        go_idle();
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < DEPTH; k++) begin
            post(1, 1'b1, AW'(k), 8'h10 + 8'(k));
            slot("b2b_write");
        end
        for (int k = 0; k < DEPTH; k++) begin
            post(1, 1'b0, AW'(k), 8'h00);
            slot("b2b_read");
        end
        go_idle();
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            for (int i = 0; i < 2; i++) begin
                if (!pend[i] && ($urandom_range(0, 1) == 1)) begin
                    post(i, bit'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH-1)),
                         WIDTH'($urandom_range(0, 255)));
                end
            end
            if (!pend[0] && !pend[1]) begin
                post(int'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                     AW'($urandom_range(0, DEPTH-1)), WIDTH'($urandom_range(0, 255)));
            end
            slot("random");
        end
        while (pend[0] || pend[1]) slot("random_drain");
        go_idle();
    endtask

    initial begin
        test_reset();
        test_unwritten();
        test_write_read();
        test_contention();
        test_reset_mid_access();
        test_both_continuous();
        test_back_to_back();
        test_random();
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_reg_bank_arbiter
